// File: rtl/bist_pkg.sv
// Shared BIST definitions: scan controller states and default LFSR constants
// used by both the PRPG and the MISR compactor.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD,
        DONE
    } state_t;

    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h01;

endpackage

// File: rtl/lfsr_prpg.sv
// Fibonacci LFSR pattern generator: loads a non-zero seed on reset or load,
// advances one step per cycle while enabled.
module lfsr_prpg
    import bist_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [WIDTH-1:0] SEED_INIT = (SEED == '0) ? WIDTH'(1) : SEED;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= SEED_INIT;
        end else if (en) begin
            q <= {q[WIDTH-2:0], ^(q & TAPS)};
        end
    end

endmodule

// File: rtl/prpg_scan_ctrl.sv
// Scan shift/capture sequencer driving PRPG stimulus into the chain and
// gating MISR compaction to the cycles that carry valid response data.
module prpg_scan_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned       WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED         = WIDTH'(DEFAULT_SEED),
    parameter int unsigned       CHAIN_LEN    = 16,
    parameter int unsigned       NUM_PATTERNS = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                scan_en,
    output logic                                scan_out,
    output logic                                grant_o,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]   pattern_cnt,
    output logic                                busy,
    output logic                                done
);

    localparam int unsigned       PC_W     = $clog2(NUM_PATTERNS + 1);
    localparam int unsigned       BC_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(CHAIN_LEN - 1);
    localparam logic [PC_W-1:0]   LAST_PAT = PC_W'(NUM_PATTERNS);

    state_t            state;
    logic [BC_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]  lfsr_q;
    logic              accept;
    logic              lfsr_en;
    logic              lfsr_unused;

    assign accept  = start && (state == IDLE || state == DONE);
    assign lfsr_en = (state == SHIFT);

    lfsr_prpg #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .en   (lfsr_en),
        .q    (lfsr_q)
    );

    // Only the MSB feeds the chain; the rest is internal LFSR state.
    assign scan_out    = lfsr_en && lfsr_q[WIDTH-1];
    assign lfsr_unused = ^lfsr_q[WIDTH-2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            pattern_cnt <= '0;
            scan_en     <= 1'b0;
            grant_o     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= SHIFT;
                        bit_cnt     <= '0;
                        pattern_cnt <= '0;
                        scan_en     <= 1'b1;
                        grant_o     <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        state   <= CAPTURE;
                        scan_en <= 1'b0;
                        grant_o <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                    end
                end
                CAPTURE: begin
                    // Every later shift or unload carries a response, so grant is always on.
                    pattern_cnt <= pattern_cnt + PC_W'(1);
                    scan_en     <= 1'b1;
                    grant_o     <= 1'b1;
                    state       <= (pattern_cnt + PC_W'(1) == LAST_PAT) ? UNLOAD : SHIFT;
                end
                UNLOAD: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        state   <= DONE;
                        scan_en <= 1'b0;
                        grant_o <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prpg_scan_ctrl.sv
// Self-checking bench for prpg_scan_ctrl: default and small configurations,
// reset abort, start filtering and a behavioural MISR signature check.
module tb_prpg_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start0, start1;
    logic       en0, out0, gnt0, busy0, done0;
    logic [7:0] pc0;
    logic       en1, out1, gnt1, busy1, done1;
    logic [1:0] pc1;

    prpg_scan_ctrl u0 (
        .clk         (clk),
        .rst         (rst),
        .start       (start0),
        .scan_en     (en0),
        .scan_out    (out0),
        .grant_o     (gnt0),
        .pattern_cnt (pc0),
        .busy        (busy0),
        .done        (done0)
    );

    prpg_scan_ctrl #(
        .CHAIN_LEN    (4),
        .NUM_PATTERNS (3)
    ) u1 (
        .clk         (clk),
        .rst         (rst),
        .start       (start1),
        .scan_en     (en1),
        .scan_out    (out1),
        .grant_o     (gnt1),
        .pattern_cnt (pc1),
        .busy        (busy1),
        .done        (done1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] seq [255];
    logic [7:0] first8 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};

    // Behavioural scan chain plus MISR on the default instance.
    logic [15:0] chain;
    logic [7:0]  misr;
    logic        misr_clr, inj;

    always @(posedge clk) begin
        if (misr_clr) begin
            chain <= '0;
            misr  <= '0;
        end else begin
            if (en0)        chain <= {chain[14:0], out0 ^ inj};
            else if (busy0) chain <= ~chain;
            if (gnt0)       misr  <= {misr[6:0], ^(misr & 8'hB8)} ^ {7'b0, chain[15]};
        end
    end

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    task automatic obs(input int sel, output logic e, output logic o, output logic g,
                       output logic b, output logic d, output logic [31:0] pc, output logic [31:0] lf);
        if (sel == 0) begin
            e = en0; o = out0; g = gnt0; b = busy0; d = done0;
            pc = {24'b0, pc0}; lf = {24'b0, u0.u_lfsr.q};
        end else begin
            e = en1; o = out1; g = gnt1; b = busy1; d = done1;
            pc = {30'b0, pc1}; lf = {24'b0, u1.u_lfsr.q};
        end
    endtask

    task automatic drive_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    task automatic run(input int sel, input bit rand_st, input bit inject, input bit chk8,
                       output logic [7:0] sig);
        int cl, np, per, body, total, p, pos, busy_n, cap_n, gnt_n;
        logic e, o, g, b, d, xe, xo, xg;
        logic [31:0] pc, lf, xpc, xlf;
        cl    = (sel == 0) ? 16 : 4;
        np    = (sel == 0) ? 255 : 3;
        per   = cl + 1;
        body  = np * per;
        total = body + cl;
        busy_n = 0; cap_n = 0; gnt_n = 0;
        @(negedge clk);
        drive_start(sel, 1'b1);
        misr_clr = 1'b1;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            if (k == 0) begin
                drive_start(sel, 1'b0);
                misr_clr = 1'b0;
            end
            obs(sel, e, o, g, b, d, pc, lf);
            if (k < body) begin
                p   = k / per;
                pos = k % per;
                xpc = p;
                if (pos < cl) begin
                    xe = 1'b1; xg = (p > 0);
                    xlf = {24'b0, seq[(p * cl + pos) % 255]};
                    xo = xlf[7];
                end else begin
                    xe = 1'b0; xg = 1'b0; xo = 1'b0;
                    xlf = {24'b0, seq[((p + 1) * cl) % 255]};
                end
            end else begin
                xe = 1'b1; xg = 1'b1; xo = 1'b0; xpc = np;
                xlf = {24'b0, seq[(np * cl) % 255]};
            end
            chk("scan_en", k, e, xe);
            chk("scan_out", k, o, xo);
            chk("grant_o", k, g, xg);
            chk("busy", k, b, 1);
            chk("done", k, d, 0);
            chk("pattern_cnt", k, pc, xpc);
            chk("lfsr", k, lf, xlf);
            if (chk8 && k < 8) chk("lfsr_first8", k, lf, first8[k]);
            busy_n += int'(b);
            cap_n  += int'(b && !e);
            gnt_n  += int'(g);
            inj = inject && (k == 7 * per + 3);
            if (rand_st) drive_start(sel, $urandom_range(0, 5) == 0);
        end
        inj = 1'b0;
        @(negedge clk);
        drive_start(sel, 1'b0);
        obs(sel, e, o, g, b, d, pc, lf);
        chk("done_end", total, d, 1);
        chk("busy_end", total, b, 0);
        chk("scan_en_end", total, e, 0);
        chk("grant_end", total, g, 0);
        chk("scan_out_end", total, o, 0);
        chk("pattern_cnt_end", total, pc, np);
        chk("lfsr_end", total, lf, {24'b0, seq[(np * cl) % 255]});
        chk("busy_cycles", total, busy_n, np * (cl + 1) + cl);
        chk("capture_cycles", total, cap_n, np);
        chk("grant_cycles", total, gnt_n, np * cl);
        sig = misr;
    endtask

    initial begin
        logic [7:0] t, sig_a, sig_b, sig_c, sig_d, sig_s;
        logic e, o, g, b, d;
        logic [31:0] pc, lf;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; misr_clr = 1'b1; inj = 1'b0;
        seq[0] = 8'h01;
        for (int i = 1; i < 255; i++) begin
            t = seq[i-1];
            seq[i] = {t[6:0], ^(t & 8'hB8)};
        end

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            obs(s, e, o, g, b, d, pc, lf);
            chk("rst_scan_en", s, e, 0);
            chk("rst_scan_out", s, o, 0);
            chk("rst_grant", s, g, 0);
            chk("rst_busy", s, b, 0);
            chk("rst_done", s, d, 0);
            chk("rst_pattern_cnt", s, pc, 0);
            chk("rst_lfsr", s, lf, 32'h01);
        end
        rst = 1'b0;

        // rst and start together: rst wins
        @(negedge clk);
        rst = 1'b1; start0 = 1'b1;
        @(negedge clk);
        chk("rst_start_busy", 0, busy0, 0);
        chk("rst_start_scan_en", 0, en0, 0);
        rst = 1'b0; start0 = 1'b0;

        run(0, 1'b0, 1'b0, 1'b1, sig_a);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run(1, 1'b1, 1'b0, 1'b0, sig_s);

        // abort in the tenth SHIFT cycle
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_busy", 9, busy0, 1);
        chk("pre_abort_lfsr", 9, {24'b0, u0.u_lfsr.q}, {24'b0, seq[9]});
        rst = 1'b1;
        @(negedge clk);
        obs(0, e, o, g, b, d, pc, lf);
        chk("abort_scan_en", 10, e, 0);
        chk("abort_scan_out", 10, o, 0);
        chk("abort_grant", 10, g, 0);
        chk("abort_busy", 10, b, 0);
        chk("abort_done", 10, d, 0);
        chk("abort_pattern_cnt", 10, pc, 0);
        chk("abort_lfsr", 10, lf, 32'h01);
        rst = 1'b0;

        run(0, 1'b0, 1'b0, 1'b1, sig_b);
        chk("sig_repeat_idle", 0, sig_b, sig_a);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run(0, 1'b1, 1'b0, 1'b1, sig_c);
        chk("sig_repeat_done", 0, sig_c, sig_a);
        run(0, 1'b0, 1'b1, 1'b0, sig_d);
        chk("sig_bitflip_differs", 0, (sig_d !== sig_a), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
